// File: rtl/matrix_piso.sv
// matrix_piso: collects up to depth_p words, then shifts them out MSB first (define PISO_PARITY_EN to append an even-parity bit per word)
module matrix_piso #(
  parameter int width_p = 8,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               flush_i,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic               data_o,
  output logic               last_o,
  output logic               busy_o
);
`ifdef PISO_PARITY_EN
  localparam int nb_lp = width_p + 1;
`else
  localparam int nb_lp = width_p;
`endif
  localparam int cw_lp = $clog2(depth_p + 1);
  localparam int bw_lp = $clog2(width_p + 1);
  localparam int aw_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [cw_lp-1:0] full_lp = cw_lp'(depth_p);
  localparam logic [bw_lp-1:0] bit_last_lp = bw_lp'(nb_lp - 1);
  typedef enum logic {FILL, SHIFT} state_e;
  state_e                 state_q, state_d;
  logic [cw_lp-1:0]       wr_cnt_q, wr_cnt_d, rd_q, rd_d;
  logic [bw_lp-1:0]       bit_q, bit_d;
  logic [nb_lp-1:0]       buf_q [depth_p];
  logic [nb_lp-1:0]       wr_word, cur_word, bit_mask;
  logic                   wr_en, last_word, last_bit;
`ifdef PISO_PARITY_EN
  assign wr_word = {data_i, ^data_i};
`else
  assign wr_word = data_i;
`endif
  assign wr_en     = (state_q == FILL) & valid_i;
  assign cur_word  = buf_q[rd_q[aw_lp-1:0]];
  assign bit_mask  = {1'b1, {(nb_lp-1){1'b0}}} >> bit_q;
  assign last_word = rd_q == wr_cnt_q - 1'b1;
  assign last_bit  = bit_q == bit_last_lp;
  // word buffer, written in FILL; contents need no reset
  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q[wr_cnt_q[aw_lp-1:0]] <= wr_word;
  end
  // state and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= FILL;
      wr_cnt_q <= '0;
      rd_q     <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_q     <= rd_d;
      bit_q    <= bit_d;
    end
  end
  // frame close on full or flush; bit/word advance on yumi; return to FILL after the last bit
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_d     = rd_q;
    bit_d    = bit_q;
    ready_o  = state_q == FILL;
    valid_o  = state_q == SHIFT;
    busy_o   = state_q == SHIFT;
    data_o   = valid_o & |(cur_word & bit_mask);
    last_o   = valid_o & last_word & last_bit;
    if (state_q == FILL) begin
      if (valid_i) wr_cnt_d = wr_cnt_q + 1'b1;
      if ((valid_i && wr_cnt_q == full_lp - 1'b1) || (flush_i && (valid_i || wr_cnt_q != '0)))
        state_d = SHIFT;
    end else if (yumi_i) begin
      bit_d = last_bit ? '0 : bit_q + 1'b1;
      rd_d  = last_bit ? rd_q + 1'b1 : rd_q;
      if (last_bit && last_word) begin
        state_d  = FILL;
        wr_cnt_d = '0;
        rd_d     = '0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_piso.sv
// tb_matrix_piso: randomized and directed checks of matrix_piso against a bit-queue reference model
module tb_matrix_piso;
  localparam int W = 8;
  localparam int D = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk_i = 0, reset_n_i = 0, valid_i = 0, flush_i = 0, yumi_i = 0;
  logic [W-1:0] data_i = '0;
  logic ready_o, valid_o, data_o, last_o, busy_o;
  int checks = 0, errors = 0;
  bit mq[$];
  bit pw[$];
  int mw;
  bit msh;
  logic [63:0] cap;
  int ncap, lastpos;
  always #5 clk_i = ~clk_i;
  matrix_piso #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o), .yumi_i(yumi_i),
    .data_o(data_o), .last_o(last_o), .busy_o(busy_o)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic m_reset();
    mq.delete();
    pw.delete();
    mw = 0;
    msh = 0;
  endtask
  task automatic m_update(input logic v, input logic [W-1:0] d, input logic f, input logic y);
    if (!msh) begin
      if (v) begin
        for (int i = W - 1; i >= 0; i--) pw.push_back(d[i]);
`ifdef PISO_PARITY_EN
        pw.push_back(^d);
`endif
        mw++;
      end
      if (mw == D || (f && mw > 0)) begin
        mq = pw;
        pw.delete();
        mw = 0;
        msh = 1;
      end
    end else if (y) begin
      void'(mq.pop_front());
      if (mq.size() == 0) msh = 0;
    end
  endtask
  task automatic clr();
    cap = '0;
    ncap = 0;
    lastpos = 0;
  endtask
  task automatic step(input logic v, input logic [W-1:0] d, input logic f, input logic y);
    @(negedge clk_i);
    check("ready", ready_o, !msh);
    check("valid", valid_o, msh);
    check("busy", busy_o, msh);
    check("data", data_o, msh ? mq[0] : 1'b0);
    check("last", last_o, msh && mq.size() == 1);
    if (valid_o && y) begin
      cap = {cap[62:0], data_o};
      ncap++;
      if (last_o) lastpos = ncap;
    end
    valid_i = v;
    data_i = d;
    flush_i = f;
    yumi_i = y;
    @(posedge clk_i);
    m_update(v, d, f, y);
  endtask
  task automatic drain(input bit bp);
    for (int i = 0; i < 300 && (msh || valid_o); i++) step(0, '0, 0, bp ? (i % 3 == 0) : 1'b1);
    check("drain_done", valid_o, 1'b0);
  endtask
  task automatic write4();
    step(1, 8'hA5, 0, 1);
    step(1, 8'h3C, 0, 1);
    step(1, 8'hFF, 0, 1);
    step(1, 8'h00, 0, 1);
  endtask
  initial begin
    m_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    reset_n_i = 1;
    clr();
    write4();
    drain(0);
`ifndef PISO_PARITY_EN
    check("full_bits", cap, 64'hA53CFF00);
`endif
    check("full_len", ncap, 4 * NB);
    check("full_last", lastpos, 4 * NB);
    step(0, '0, 0, 0);
    clr();
    step(1, 8'h81, 0, 1);
    step(1, 8'h7E, 0, 1);
    step(0, '0, 1, 1);
    drain(0);
`ifndef PISO_PARITY_EN
    check("flush_bits", cap, 64'h817E);
`endif
    check("flush_len", ncap, 2 * NB);
    check("flush_last", lastpos, 2 * NB);
    repeat (3) step(0, '0, 1, 1);
    check("flush0_valid", valid_o, 1'b0);
    clr();
    write4();
    drain(1);
`ifndef PISO_PARITY_EN
    check("bp_bits", cap, 64'hA53CFF00);
`endif
    check("bp_len", ncap, 4 * NB);
    check("bp_last", lastpos, 4 * NB);
    clr();
    step(1, 8'h12, 0, 0);
    step(0, '0, 1, 0);
    repeat (3) step(1, 8'h55, 0, 0);
    drain(0);
`ifndef PISO_PARITY_EN
    check("block_bits", cap, 64'h12);
`endif
    check("block_len", ncap, NB);
    clr();
    step(1, 8'h9C, 0, 0);
    step(1, 8'hE3, 1, 0);
    drain(0);
`ifndef PISO_PARITY_EN
    check("wf_bits", cap, 64'h9CE3);
`endif
    check("wf_len", ncap, 2 * NB);
    write4();
    repeat (5) step(0, '0, 0, 1);
    @(negedge clk_i);
    reset_n_i = 0;
    #1;
    check("mrst_ready", ready_o, 1'b1);
    check("mrst_valid", valid_o, 1'b0);
    check("mrst_data", data_o, 1'b0);
    check("mrst_last", last_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    m_reset();
    valid_i = 0;
    flush_i = 0;
    yumi_i = 0;
    @(negedge clk_i);
    reset_n_i = 1;
    clr();
    step(1, 8'h12, 0, 1);
    step(0, '0, 1, 1);
    drain(0);
`ifndef PISO_PARITY_EN
    check("post_rst_bits", cap, 64'h12);
`endif
    check("post_rst_len", ncap, NB);
    check("post_rst_last", lastpos, NB);
`ifdef PISO_PARITY_EN
    clr();
    step(1, 8'hA5, 0, 1);
    step(1, 8'h07, 0, 1);
    step(0, '0, 1, 1);
    drain(0);
    check("par_bits", cap, 64'h2940F);
    check("par_len", ncap, 18);
    check("par_last", lastpos, 18);
`endif
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    drain(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
